// File: rtl/enc_slice_streamer_pkg.sv
// Shared sizing, types and helpers for the encoder slice streamer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package enc_pkg;

  localparam int FEATURE_COUNT = 617;
  localparam int HV_DIM        = 5000;
  localparam int DIMS_PER_CC   = 500;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // A counter always needs at least one bit, even for a single-slice pass.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_SLICES = ceil_div(HV_DIM, DIMS_PER_CC);
  localparam int CTR_W      = ctr_width(NUM_SLICES);

  typedef logic [FEATURE_COUNT-1:0] feat_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } stream_state_e;

endpackage

// File: rtl/enc_slice_streamer_if.sv
// Slice beat bus from the streamer to the bundling counters.
// Latency: n/a (wires only).
// Backpressure: valid/ready; master holds payload while valid && !ready.
interface enc_slice_streamer_if #(
  parameter int FEATURE_COUNT = enc_pkg::FEATURE_COUNT,
  parameter int DIMS_PER_CC   = enc_pkg::DIMS_PER_CC,
  parameter int CTR_W         = enc_pkg::CTR_W
);
  logic [FEATURE_COUNT-1:0] mux_out [DIMS_PER_CC];
  logic                     out_valid;
  logic                     out_ready;
  logic [CTR_W-1:0]         slice_idx;
  logic                     last;

  modport master (output mux_out, output out_valid, output slice_idx, output last,
                  input  out_ready);
  modport slave  (input  mux_out, input  out_valid, input  slice_idx, input  last,
                  output out_ready);
endinterface

// File: rtl/enc_slice_streamer_select.sv
// Picks slice sel_i out of the source array; lanes past HV_DIM read as zero.
// Latency: combinational.
// Backpressure: none (pure select).
module enc_slice_select
  import enc_pkg::*;
#(
  parameter int FEATURE_COUNT = enc_pkg::FEATURE_COUNT,
  parameter int HV_DIM        = enc_pkg::HV_DIM,
  parameter int DIMS_PER_CC   = enc_pkg::DIMS_PER_CC,
  parameter int CTR_W         = enc_pkg::CTR_W
) (
  input  logic [CTR_W-1:0]         sel_i,
  input  logic [FEATURE_COUNT-1:0] arr_i   [HV_DIM],
  output logic [FEATURE_COUNT-1:0] slice_o [DIMS_PER_CC]
);

  localparam int IDX_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  for (genvar j = 0; j < DIMS_PER_CC; j++) begin : g_lane
    int dim;
    assign dim = int'(sel_i) * DIMS_PER_CC + j;
    // The partial final slice is zero-filled rather than reading out of range.
    assign slice_o[j] = (dim < HV_DIM) ? arr_i[idx_t'(dim)] : '0;
  end

endmodule

// File: rtl/enc_slice_streamer.sv
// Streams a hypervector to the bundler, DIMS_PER_CC dimensions per beat, with start/abort/done.
// Latency: first beat valid 2 cycles after start; back-to-back beats under out_ready=1; done 1 cycle after last beat.
// Backpressure: valid/ready; payload held bit-stable while out_valid && !out_ready.
module enc_slice_streamer
  import enc_pkg::*;
#(
  parameter int FEATURE_COUNT = enc_pkg::FEATURE_COUNT,
  parameter int HV_DIM        = enc_pkg::HV_DIM,
  parameter int DIMS_PER_CC   = enc_pkg::DIMS_PER_CC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FEATURE_COUNT-1:0] bits_to_bundle_arr [HV_DIM],
  enc_slice_streamer_if.master     out_if,
  output logic                     busy,
  output logic                     done
);

  localparam int NUM_SLICES = ceil_div(HV_DIM, DIMS_PER_CC);
  localparam int CTR_W      = ctr_width(NUM_SLICES);
  typedef logic [CTR_W-1:0] ctr_t;
  localparam ctr_t LAST_IDX = ctr_t'(NUM_SLICES - 1);

  stream_state_e            state_q, state_d;
  ctr_t                     ctr_q, ctr_d, sel;
  logic                     vld_q, vld_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;
  logic                     load_en;
  logic [FEATURE_COUNT-1:0] slice   [DIMS_PER_CC];
  logic [FEATURE_COUNT-1:0] mux_q   [DIMS_PER_CC];

  enc_slice_select #(
    .FEATURE_COUNT (FEATURE_COUNT),
    .HV_DIM        (HV_DIM),
    .DIMS_PER_CC   (DIMS_PER_CC),
    .CTR_W         (CTR_W)
  ) u_select (
    .sel_i   (sel),
    .arr_i   (bits_to_bundle_arr),
    .slice_o (slice)
  );

  // Next state: abort beats everything; a handshake loads the next slice in the same edge.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load_en = 1'b0;
    sel     = '0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = STREAM;
          load_en = 1'b1;
          sel     = '0;
          ctr_d   = '0;
          vld_d   = 1'b1;
          last_d  = (LAST_IDX == '0);
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          ctr_d   = '0;
          last_d  = 1'b0;
        end else if (vld_q && out_if.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            ctr_d   = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load_en = 1'b1;
            sel     = ctr_q + ctr_t'(1);
            ctr_d   = sel;
            last_d  = (sel == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output register; payload only moves on a load so stalls hold it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < DIMS_PER_CC; j++) mux_q[j] <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      if (load_en) begin
        for (int j = 0; j < DIMS_PER_CC; j++) mux_q[j] <= slice[j];
      end
    end
  end

  assign out_if.mux_out   = mux_q;
  assign out_if.out_valid = vld_q;
  assign out_if.slice_idx = ctr_q;
  assign out_if.last      = last_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule

// File: tb/tb_enc_slice_streamer.sv
// Bench for enc_slice_streamer: default sizing plus a 1050-dim instance with a partial slice.
// Latency: n/a.
// Backpressure: out_ready driven randomly or held high per scenario.
module tb_enc_slice_streamer;
  import enc_pkg::*;

  localparam int NS_A  = 10;
  localparam int CW_A  = 4;
  localparam int HV_A  = 5000;
  localparam int HV_B  = 1050;
  localparam int NS_B  = 3;
  localparam int CW_B  = 2;
  localparam int DPC   = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst_n_a, start_a, abort_a, busy_a, done_a;
  logic      rst_n_b, start_b, abort_b, busy_b, done_b;
  feat_vec_t arr_a [HV_A];
  feat_vec_t arr_b [HV_B];

  enc_slice_streamer_if #(.FEATURE_COUNT(FEATURE_COUNT), .DIMS_PER_CC(DPC), .CTR_W(CW_A)) if_a ();
  enc_slice_streamer_if #(.FEATURE_COUNT(FEATURE_COUNT), .DIMS_PER_CC(DPC), .CTR_W(CW_B)) if_b ();

  enc_slice_streamer dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
    .bits_to_bundle_arr(arr_a), .out_if(if_a), .busy(busy_a), .done(done_a)
  );

  enc_slice_streamer #(.FEATURE_COUNT(FEATURE_COUNT), .HV_DIM(HV_B), .DIMS_PER_CC(DPC)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
    .bits_to_bundle_arr(arr_b), .out_if(if_b), .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic feat_vec_t rand_vec();
    logic [639:0] t;
    for (int w = 0; w < 20; w++) t[w*32 +: 32] = $urandom;
    return t[FEATURE_COUNT-1:0];
  endfunction

  // Reference: slice k lane j is dimension k*DPC+j, or zero beyond the hypervector.
  function automatic int bad_lanes_a(input int k);
    int n = 0;
    for (int j = 0; j < DPC; j++) begin
      feat_vec_t e;
      e = (k*DPC + j < HV_A) ? arr_a[k*DPC + j] : '0;
      if (if_a.mux_out[j] !== e) n++;
    end
    return n;
  endfunction

  function automatic int bad_lanes_b(input int k);
    int n = 0;
    for (int j = 0; j < DPC; j++) begin
      feat_vec_t e;
      e = (k*DPC + j < HV_B) ? arr_b[k*DPC + j] : '0;
      if (if_b.mux_out[j] !== e) n++;
    end
    return n;
  endfunction

  function automatic int nonzero_lanes_a();
    int n = 0;
    for (int j = 0; j < DPC; j++) if (if_a.mux_out[j] !== '0) n++;
    return n;
  endfunction

  function automatic int nonzero_lanes_b();
    int n = 0;
    for (int j = 0; j < DPC; j++) if (if_b.mux_out[j] !== '0) n++;
    return n;
  endfunction

  // One pass on dut_a; abort_k/start_k/rst_k pick the slice where that event is injected (-1 = never).
  task automatic pass_a(input bit rnd, input int abort_k, input int start_k, input int rst_k, input bit chain);
    int k = 0;
    int guard = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_eq("load_busy", busy_a, 1);
    check_eq("load_vld", if_a.out_valid, 0);
    step();
    while (k < NS_A && guard < 300) begin
      guard++;
      check_eq("vld", if_a.out_valid, 1);
      check_eq("idx", if_a.slice_idx, k);
      check_eq("last", if_a.last, (k == NS_A-1));
      check_eq("lanes", bad_lanes_a(k), 0);
      check_eq("done_mid", done_a, 0);
      check_eq("busy_mid", busy_a, 1);
      if (k == abort_k) begin
        if_a.out_ready = 1'b1;
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        check_eq("abort_vld", if_a.out_valid, 0);
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_done", done_a, 0);
        check_eq("abort_idx", if_a.slice_idx, 0);
        step();
        check_eq("abort_done2", done_a, 0);
        return;
      end
      if (k == rst_k) begin
        if_a.out_ready = 1'b0;
        rst_n_a = 1'b0;
        step();
        rst_n_a = 1'b1;
        check_eq("rst_vld", if_a.out_valid, 0);
        check_eq("rst_idx", if_a.slice_idx, 0);
        check_eq("rst_last", if_a.last, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_data", nonzero_lanes_a(), 0);
        step();
        check_eq("rst_done2", done_a, 0);
        check_eq("rst_busy2", busy_a, 0);
        return;
      end
      if_a.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_a = (k == start_k);
      if (if_a.out_ready) begin
        step();
        k++;
      end else begin
        step();
      end
      start_a = 1'b0;
    end
    check_eq("beats", k, NS_A);
    check_eq("done_pulse", done_a, 1);
    check_eq("done_vld", if_a.out_valid, 0);
    check_eq("done_busy", busy_a, 0);
    start_a = chain;
    step();
    start_a = 1'b0;
    check_eq("done_clr", done_a, 0);
    check_eq("chain_busy", busy_a, chain);
    if (chain) begin
      step();
      check_eq("chain_vld", if_a.out_valid, 1);
      check_eq("chain_idx", if_a.slice_idx, 0);
      if_a.out_ready = 1'b0;
      abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      check_eq("chain_abort", busy_a, 0);
    end
  endtask

  initial begin
    rst_n_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; if_a.out_ready = 1'b0;
    rst_n_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; if_b.out_ready = 1'b0;
    for (int i = 0; i < HV_A; i++) arr_a[i] = rand_vec();
    for (int i = 0; i < HV_B; i++) arr_b[i] = rand_vec();
    step();
    step();
    check_eq("rst_vld_a", if_a.out_valid, 0);
    check_eq("rst_idx_a", if_a.slice_idx, 0);
    check_eq("rst_last_a", if_a.last, 0);
    check_eq("rst_done_a", done_a, 0);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_data_a", nonzero_lanes_a(), 0);
    check_eq("rst_data_b", nonzero_lanes_b(), 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    step();
    check_eq("idle_busy", busy_a, 0);

    pass_a(1'b0, -1, -1, -1, 1'b0);   // full rate
    pass_a(1'b1, -1, 3, -1, 1'b1);    // random stalls, stray start, start on done
    pass_a(1'b0, 4, -1, -1, 1'b0);    // abort on slice 4 handshake
    pass_a(1'b0, -1, -1, -1, 1'b0);   // restart from slice 0

    start_a = 1'b1;
    abort_a = 1'b1;
    step();
    start_a = 1'b0;
    abort_a = 1'b0;
    check_eq("sa_busy", busy_a, 0);
    step();
    check_eq("sa_vld", if_a.out_valid, 0);

    pass_a(1'b1, -1, -1, 6, 1'b0);    // reset while stalled on slice 6
    for (int i = 0; i < HV_A; i++) arr_a[i] = rand_vec();
    pass_a(1'b1, -1, -1, -1, 1'b0);

    // Partial final slice on the 1050-dim instance.
    if_b.out_ready = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_eq("b_load_busy", busy_b, 1);
    step();
    for (int k = 0; k < NS_B; k++) begin
      check_eq("b_vld", if_b.out_valid, 1);
      check_eq("b_idx", if_b.slice_idx, k);
      check_eq("b_last", if_b.last, (k == NS_B-1));
      check_eq("b_lanes", bad_lanes_b(k), 0);
      step();
    end
    check_eq("b_done", done_b, 1);
    check_eq("b_vld_end", if_b.out_valid, 0);
    step();
    check_eq("b_done_clr", done_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
